// File: rtl/base_rdemux.sv
// Registered one-hot demultiplexer: one single-entry output register per way.
// Optional select checking is compiled in with `define BASE_RDEMUX_CHK_EN.
module base_rdemux #(
  parameter int ways  = 2,
  parameter int width = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_v,
  input  logic [0:width-1]         i_d,
  input  logic [0:ways-1]          i_sel,
  output logic                     i_r,
  output logic [0:ways-1]          o_v,
  output logic [0:(ways*width)-1]  o_d,
  input  logic [0:ways-1]          o_r,
  output logic                     o_err,
  output logic [0:7]               o_errcnt
);

  function automatic logic [0:ways-1] lowest_set(input logic [0:ways-1] s);
    logic [0:ways-1] r;
    logic            found;
    r     = {ways{1'b0}};
    found = 1'b0;
    for (int k = 0; k < ways; k++) begin
      r[k]  = s[k] & ~found;
      found = found | s[k];
    end
    return r;
  endfunction

  logic [0:ways-1]         full_q, full_d;
  logic [0:(ways*width)-1] data_q, data_d;
  logic [0:ways-1]         sel_eff_s;
  logic [0:ways-1]         room_s;
  logic                    illegal_s;
  logic                    take_s;

`ifdef BASE_RDEMUX_CHK_EN
  function automatic logic is_onehot(input logic [0:ways-1] s);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int k = 0; k < ways; k++) begin
      multi = multi | (seen & s[k]);
      seen  = seen | s[k];
    end
    return seen & ~multi;
  endfunction

  assign illegal_s = ~is_onehot(i_sel);
`else
  assign illegal_s = 1'b0;
`endif

  // Ready: an illegal select is always swallowed; a legal one needs room in its way.
  always_comb begin
    sel_eff_s = illegal_s ? {ways{1'b0}} : lowest_set(i_sel);
    room_s    = sel_eff_s & (~full_q | o_r);
    i_r       = ~reset & (illegal_s | (|room_s));
    take_s    = i_v & i_r;
  end

  // Next state of the per-way registers; a load wins over a same-cycle drain.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    for (int k = 0; k < ways; k++) begin
      if (take_s && sel_eff_s[k]) begin
        full_d[k]                 = 1'b1;
        data_d[k*width +: width]  = i_d;
      end else if (full_q[k] && o_r[k]) begin
        full_d[k] = 1'b0;
      end else begin
        full_d[k] = full_q[k];
      end
    end
  end

  // Per-way output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= {ways{1'b0}};
      data_q <= {(ways*width){1'b0}};
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign o_v = full_q;
  assign o_d = data_q;

`ifdef BASE_RDEMUX_CHK_EN
  logic       err_q, err_d;
  logic [0:7] cnt_q, cnt_d;

  // Sticky error flag and saturating count of dropped beats.
  always_comb begin
    if (i_v && i_r && illegal_s) begin
      err_d = 1'b1;
      cnt_d = (cnt_q == 8'd255) ? cnt_q : cnt_q + 8'd1;
    end else begin
      err_d = err_q;
      cnt_d = cnt_q;
    end
  end

  // Error state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_err    = err_q;
  assign o_errcnt = cnt_q;
`else
  assign o_err    = 1'b0;
  assign o_errcnt = 8'd0;
`endif

endmodule

// File: tb/tb_base_rdemux.sv
// Directed self-checking bench for base_rdemux (ways=4, width=8).
// Select-check expectations follow `BASE_RDEMUX_CHK_EN.
module tb_base_rdemux;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_v;
  logic [0:7]  i_d;
  logic [0:3]  i_sel;
  logic        i_r;
  logic [0:3]  o_v;
  logic [0:31] o_d;
  logic [0:3]  o_r;
  logic        o_err;
  logic [0:7]  o_errcnt;

  int vec  = 0;
  int miss = 0;

  base_rdemux #(.ways(4), .width(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_v      (i_v),
    .i_d      (i_d),
    .i_sel    (i_sel),
    .i_r      (i_r),
    .o_v      (o_v),
    .o_d      (o_d),
    .o_r      (o_r),
    .o_err    (o_err),
    .o_errcnt (o_errcnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] way(input int k);
    return o_d[k*8 +: 8];
  endfunction

  initial begin
    // Reset with a beat presented: it must not be accepted.
    reset = 1'b1; i_v = 1'b1; i_d = 8'hEE; i_sel = 4'b1000; o_r = 4'b1111;
    tick; tick;
    chk("rst_ir", i_r, 1'b0);
    chk("rst_ov", o_v, 4'b0000);
    chk("rst_od", o_d, 32'h0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_cnt", o_errcnt, 8'd0);
    reset = 1'b0; i_v = 1'b0;
    tick;
    chk("post_rst_ov", o_v, 4'b0000);

    // Single beat to way 2, one-cycle latency.
    i_v = 1'b1; i_d = 8'hA5; i_sel = 4'b0010; #1;
    chk("b1_ir", i_r, 1'b1);
    tick; i_v = 1'b0;
    chk("b1_ov", o_v, 4'b0010);
    chk("b1_w2", way(2), 8'hA5);
    tick;
    chk("b1_ov_next", o_v, 4'b0000);

    // Backpressure on way 1, then simultaneous drain and load.
    o_r = 4'b1011; i_v = 1'b1; i_d = 8'h11; i_sel = 4'b0100; #1;
    chk("bp_ir0", i_r, 1'b1);
    tick; i_d = 8'h22; #1;
    chk("bp_ir1", i_r, 1'b0);
    chk("bp_ov1", o_v, 4'b0100);
    chk("bp_w1a", way(1), 8'h11);
    tick;
    chk("bp_w1b", way(1), 8'h11);
    chk("bp_ov2", o_v, 4'b0100);
    o_r = 4'b1111; #1;
    chk("bp_ir2", i_r, 1'b1);
    tick; i_v = 1'b0;
    chk("bp_ov3", o_v, 4'b0100);
    chk("bp_w1c", way(1), 8'h22);
    tick;
    chk("bp_ov4", o_v, 4'b0000);

    // Stalled way 0 must not block way 3.
    o_r = 4'b0111; i_v = 1'b1; i_d = 8'h5A; i_sel = 4'b1000;
    tick; i_d = 8'h33; i_sel = 4'b0001; #1;
    chk("st_ir", i_r, 1'b1);
    chk("st_ov0", o_v, 4'b1000);
    tick; i_v = 1'b0;
    chk("st_ov1", o_v, 4'b1001);
    chk("st_w3", way(3), 8'h33);
    chk("st_w0a", way(0), 8'h5A);
    tick;
    chk("st_ov2", o_v, 4'b1000);
    chk("st_w0b", way(0), 8'h5A);

`ifdef BASE_RDEMUX_CHK_EN
    // Zero-hot and multi-hot selects are accepted and dropped.
    i_v = 1'b1; i_d = 8'h66; i_sel = 4'b0000; #1;
    chk("ill_ir0", i_r, 1'b1);
    tick; i_d = 8'h77; i_sel = 4'b1100; #1;
    chk("ill_ir1", i_r, 1'b1);
    tick; i_v = 1'b0;
    chk("ill_ov", o_v, 4'b1000);
    chk("ill_w1", way(1), 8'h22);
    chk("ill_err", o_err, 1'b1);
    chk("ill_cnt2", o_errcnt, 8'd2);
    i_v = 1'b1; i_sel = 4'b0000;
    repeat (300) tick;
    i_v = 1'b0;
    tick;
    chk("ill_cnt_sat", o_errcnt, 8'd255);
    chk("ill_err_sticky", o_err, 1'b1);
    chk("ill_ov2", o_v, 4'b1000);
`else
    // Multi-hot picks the lowest way; zero-hot stalls.
    i_v = 1'b1; i_d = 8'h44; i_sel = 4'b0110; #1;
    chk("mh_ir", i_r, 1'b1);
    tick; i_v = 1'b0;
    chk("mh_ov", o_v, 4'b1100);
    chk("mh_w1", way(1), 8'h44);
    chk("mh_w2", way(2), 8'hA5);
    i_v = 1'b1; i_sel = 4'b0000; #1;
    chk("zh_ir", i_r, 1'b0);
    tick; i_v = 1'b0;
    chk("zh_ov", o_v, 4'b1000);
    chk("zh_err", o_err, 1'b0);
    chk("zh_cnt", o_errcnt, 8'd0);
`endif

    // Mid-operation reset with ways 0 and 2 full.
    o_r = 4'b0101; i_v = 1'b1; i_d = 8'h99; i_sel = 4'b0010;
    tick; i_v = 1'b0;
    chk("mr_ov_pre", o_v, 4'b1010);
    chk("mr_w2", way(2), 8'h99);
    reset = 1'b1;
    tick;
    chk("mr_ov", o_v, 4'b0000);
    chk("mr_od", o_d, 32'h0);
    chk("mr_err", o_err, 1'b0);
    chk("mr_cnt", o_errcnt, 8'd0);
    chk("mr_ir", i_r, 1'b0);
    reset = 1'b0; o_r = 4'b1111; i_v = 1'b1; i_d = 8'hC3; i_sel = 4'b0001; #1;
    chk("ar_ir", i_r, 1'b1);
    tick; i_v = 1'b0;
    chk("ar_ov", o_v, 4'b0001);
    chk("ar_w3", way(3), 8'hC3);
    tick;
    chk("ar_ov2", o_v, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
